mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to single-port memory arbiter for the 16-bit pipelined `cpu`. It shares one unified memory (`memory` instance) between the instruction-fetch port and the data port. Each accepted request becomes one fixed-latency memory access, followed by a one-cycle acknowledge. The block sits between `cpu` (i_*/d_* sides) and the memory model, replacing the separate instruction/data memories in single-memory builds.

## Interface
- `WORD_SIZE`, default 16: width of address and data words.
- `LATENCY`, default 2: cycles `m_readM`/`m_writeM` are held per access. Legal range 1..15.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock for the block.
- `reset` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch request, held until `i_ack`.
- `i_address` in WORD_SIZE: fetch address, stable while `i_req`.
- `i_rdata` out WORD_SIZE: fetched word, valid while `i_ack`.
- `i_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_address` in WORD_SIZE: data address.
- `d_wdata` in WORD_SIZE: write data.
- `d_rdata` out WORD_SIZE: read data, valid while `d_ack`.
- `d_ack` out 1: one-cycle completion pulse.
- `m_readM` out 1: memory read strobe.
- `m_writeM` out 1: memory write strobe.
- `m_address` out WORD_SIZE: memory address.
- `m_wdata` out WORD_SIZE: memory write data.
- `m_rdata` in WORD_SIZE: memory read data, valid at the last access cycle.
- `grant_d` out 1: 1 while the current or last access belongs to the data port.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - At each rising edge, sample `i_req`/`d_req`.
  - If any request is present: grant it, latch address/we/wdata into `m_*` registers, load cnt = LATENCY, go to ACCESS.
  - If no request is present: stay in IDLE.
- Arbitration (default): `d_req` has priority over `i_req` when both are high in the same cycle.
- ACCESS:
  - `m_readM` (read) or `m_writeM` (write) is high and cnt decrements each edge.
  - At the edge where cnt == 1: capture `m_rdata` into the granted port's rdata register (reads only), deassert strobes, go to ACK.
- ACK:
  - The granted port's ack is high for exactly one cycle; next state is IDLE.
  - On a write, `d_rdata` keeps its previous value.
- A request is never granted in ACK or ACCESS. A `req` still high at the first IDLE sampling edge after ACK is treated as a new request.
- Dropping `req` mid-access does not abort the access: it completes and ack still pulses.
- The ungranted port's address/data inputs are ignored. `m_address`/`m_wdata` hold their last values while in IDLE.
- `i_*` side never writes; `m_writeM` is asserted only for `d_we`=1 grants.

## Timing
- Reset (async, immediate) forces: state IDLE; `m_readM`=`m_writeM`=0; `m_address`=`m_wdata`=0; `i_rdata`=`d_rdata`=0; `i_ack`=`d_ack`=0; `grant_d`=0; round-robin pointer = "last granted I".
- Reset asserted mid-access: the access is abandoned, no ack is issued, strobes drop the same cycle.
- Request sampled at edge E:
  - Strobes are high from E to E+LATENCY.
  - `m_rdata` is sampled at edge E+LATENCY.
  - ack is high in the cycle E+LATENCY to E+LATENCY+1.
  - The next grant is possible at edge E+LATENCY+2.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- All outputs are registered; no combinational path from `*_req` to `m_*` or to acks.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- Defined:
  - A 1-bit last-grant pointer is updated on every grant.
  - On simultaneous requests, the port not granted last wins.
  - Reset pointer = I, so the first conflict goes to D.
  - Single requests are granted regardless of the pointer.
- Undefined: the pointer is not built; fixed D-over-I priority, so a continuous `d_req` can starve `i_req`.

## Test plan
- Reset mid-read: with LATENCY=2 and a read of address 0x0010 in ACCESS, assert `reset` → strobes 0 at once, no `i_ack`, all outputs 0; after release, the next `i_req` behaves normally.
- Lone fetch: `i_req`=1, `i_address`=0x0004, memory word 0x7C00, request sampled at edge E:
  - `m_readM`=1 at E and E+1; `m_address`=0x0004.
  - `i_ack`=1 for one cycle after E+2 with `i_rdata`=0x7C00; `grant_d`=0.
- Data write: `d_req`=1, `d_we`=1, `d_address`=0x0002, `d_wdata`=0xBEEF → `m_writeM`=1 for 2 cycles, `m_readM`=0, `d_ack` pulses once, memory[2]=0xBEEF, `d_rdata` unchanged.
- Conflict, default build: `i_req` and `d_req` (read 0x0008=0x1234) raised in the same cycle, both held:
  - D is granted first: `d_ack` with 0x1234.
  - I is granted at the next IDLE edge, 4 cycles after the first grant.
- Conflict with `ARB_ROUND_ROBIN_EN` defined, both requests held continuously for 4 grants → grant order D, I, D, I. Without the macro, the same stimulus with `d_req` re-raised each time → D, D, D, D.
- Requester drop: `i_req` deasserted one cycle after grant → access completes, `i_ack` still pulses, and no second fetch is issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between the CPU fetch port (i_*) and data port (d_*).
// Define ARB_ROUND_ROBIN_EN to alternate priority on conflicts instead of fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 grant_d
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_e;

    state_e               state_q,   state_d;
    logic [3:0]           cnt_q,     cnt_d;
    logic                 grantD_q,  grantD_d;
    logic                 mReadM_q,  mReadM_d;
    logic                 mWriteM_q, mWriteM_d;
    logic [WORD_SIZE-1:0] mAddress_q, mAddress_d;
    logic [WORD_SIZE-1:0] mWdata_q,  mWdata_d;
    logic [WORD_SIZE-1:0] iRdata_q,  iRdata_d;
    logic [WORD_SIZE-1:0] dRdata_q,  dRdata_d;
    logic                 iAck_q,    iAck_d;
    logic                 dAck_q,    dAck_d;
    logic                 pickD;
`ifdef ARB_ROUND_ROBIN_EN
    logic                 lastD_q,   lastD_d;
`endif

    // On a conflict the data port wins, unless round-robin says it was served last.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pickD = d_req && (!i_req || !lastD_q);
`else
        pickD = d_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grantD_d   = grantD_q;
        mReadM_d   = mReadM_q;
        mWriteM_d  = mWriteM_q;
        mAddress_d = mAddress_q;
        mWdata_d   = mWdata_q;
        iRdata_d   = iRdata_q;
        dRdata_d   = dRdata_q;
        iAck_d     = 1'b0;
        dAck_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        lastD_d    = lastD_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d  = ACCESS;
                    cnt_d    = 4'(LATENCY);
                    grantD_d = pickD;
`ifdef ARB_ROUND_ROBIN_EN
                    lastD_d  = pickD;
`endif
                    if (pickD) begin
                        mAddress_d = d_address;
                        mWdata_d   = d_wdata;
                        mReadM_d   = !d_we;
                        mWriteM_d  = d_we;
                    end else begin
                        mAddress_d = i_address;
                        mReadM_d   = 1'b1;
                        mWriteM_d  = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd1) begin
                    state_d   = ACK;
                    mReadM_d  = 1'b0;
                    mWriteM_d = 1'b0;
                    // Read data is only meaningful on the last strobe cycle; writes leave rdata untouched.
                    if (mReadM_q) begin
                        if (grantD_q) dRdata_d = m_rdata;
                        else          iRdata_d = m_rdata;
                    end
                    if (grantD_q) dAck_d = 1'b1;
                    else          iAck_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            grantD_q   <= 1'b0;
            mReadM_q   <= 1'b0;
            mWriteM_q  <= 1'b0;
            mAddress_q <= '0;
            mWdata_q   <= '0;
            iRdata_q   <= '0;
            dRdata_q   <= '0;
            iAck_q     <= 1'b0;
            dAck_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            lastD_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grantD_q   <= grantD_d;
            mReadM_q   <= mReadM_d;
            mWriteM_q  <= mWriteM_d;
            mAddress_q <= mAddress_d;
            mWdata_q   <= mWdata_d;
            iRdata_q   <= iRdata_d;
            dRdata_q   <= dRdata_d;
            iAck_q     <= iAck_d;
            dAck_q     <= dAck_d;
`ifdef ARB_ROUND_ROBIN_EN
            lastD_q    <= lastD_d;
`endif
        end
    end

    assign i_rdata   = iRdata_q;
    assign i_ack     = iAck_q;
    assign d_rdata   = dRdata_q;
    assign d_ack     = dAck_q;
    assign m_readM   = mReadM_q;
    assign m_writeM  = mWriteM_q;
    assign m_address = mAddress_q;
    assign m_wdata   = mWdata_q;
    assign grant_d   = grantD_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus corner-case sequences for mem_arbiter with a small memory model.
// Acks are scored against a queue of expected {port, data} filled when stimulus is driven.
module tb_mem_arbiter;

    localparam int LAT = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        iReq, dReq, dWe;
    logic [15:0] iAddress, dAddress, dWdata;
    logic [15:0] iRdata, dRdata, mAddress, mWdata, mRdata;
    logic        iAck, dAck, mReadM, mWriteM, grantD;
    logic        memLoad;

    mem_arbiter #(.WORD_SIZE(16), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(iReq), .i_address(iAddress), .i_rdata(iRdata), .i_ack(iAck),
        .d_req(dReq), .d_we(dWe), .d_address(dAddress), .d_wdata(dWdata),
        .d_rdata(dRdata), .d_ack(dAck),
        .m_readM(mReadM), .m_writeM(mWriteM), .m_address(mAddress),
        .m_wdata(mWdata), .m_rdata(mRdata), .grant_d(grantD)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] initWord(input logic [7:0] a);
        case (a)
            8'h04:   return 16'h7C00;
            8'h08:   return 16'h1234;
            8'h10:   return 16'h0ABC;
            default: return {a, ~a};
        endcase
    endfunction

    // Memory model: combinational read, write on each strobed edge.
    logic [15:0] mem [0:255];
    always @(posedge clk or posedge memLoad) begin
        if (memLoad) begin
            for (int k = 0; k < 256; k++) mem[k] <= initWord(8'(k));
        end else if (mWriteM) begin
            mem[mAddress[7:0]] <= mWdata;
        end
    end
    assign mRdata = mem[mAddress[7:0]];

    typedef struct packed {
        logic        iReq;
        logic        dReq;
        logic        dWe;
        logic [15:0] iAddr;
        logic [15:0] dAddr;
        logic [15:0] dWdata;
        logic        expDFixed;
        logic        expDRr;
    } vec_t;

    typedef struct packed {
        logic        isD;
        logic [15:0] data;
    } exp_t;

    vec_t        vecs [12];
    exp_t        sbQ [$];
    logic [15:0] refMem [0:255];
    logic [15:0] dRdModel;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic vec_t mkVec(input logic ir, input logic dr, input logic we,
                                   input logic [15:0] ia, input logic [15:0] da,
                                   input logic [15:0] wd, input logic ef, input logic er);
        vec_t v;
        v.iReq = ir; v.dReq = dr; v.dWe = we;
        v.iAddr = ia; v.dAddr = da; v.dWdata = wd;
        v.expDFixed = ef; v.expDRr = er;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushExpect(input logic isD, input logic we, input logic [15:0] addr,
                              input logic [15:0] wdata);
        exp_t e;
        e.isD = isD;
        if (isD && we) begin
            refMem[addr[7:0]] = wdata;
            e.data = dRdModel;
        end else if (isD) begin
            dRdModel = refMem[addr[7:0]];
            e.data = dRdModel;
        end else begin
            e.data = refMem[addr[7:0]];
        end
        sbQ.push_back(e);
    endtask

    // Advance to the next falling edge and score any acknowledge seen there.
    task automatic scoreCycle(output logic acked);
        exp_t e;
        @(negedge clk);
        acked = iAck | dAck;
        if (iAck && dAck) begin
            checkOutput("dual_ack", 32'd1, 32'd0);
        end else if (acked) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_ack", {30'd0, dAck, iAck}, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("ack_port", dAck, e.isD);
                checkOutput("grant_d", grantD, e.isD);
                checkOutput("rdata", dAck ? dRdata : iRdata, e.data);
            end
        end
    endtask

    task automatic waitAck(input string name, output int n);
        logic acked;
        n = 0;
        do begin
            scoreCycle(acked);
            n++;
        end while (!acked && n < 40);
        checkOutput({name, "_ack_seen"}, acked, 1'b1);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic acked;
        logic expD;
        int   n;
        expD = RR ? v.expDRr : v.expDFixed;
        scoreCycle(acked);
        iReq = v.iReq; dReq = v.dReq; dWe = v.dWe;
        iAddress = v.iAddr; dAddress = v.dAddr; dWdata = v.dWdata;
        pushExpect(expD, v.dWe, expD ? v.dAddr : v.iAddr, v.dWdata);
        scoreCycle(acked);
        checkOutput("m_readM", mReadM, expD ? !v.dWe : 1'b1);
        checkOutput("m_writeM", mWriteM, expD & v.dWe);
        checkOutput("m_address", mAddress, expD ? v.dAddr : v.iAddr);
        if (expD && v.dWe) checkOutput("m_wdata", mWdata, v.dWdata);
        waitAck("vec", n);
        checkOutput("ack_latency", n + 1, LAT + 1);
        iReq = 1'b0; dReq = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_strobes_acks", {mReadM, mWriteM, iAck, dAck, grantD}, 5'd0);
        checkOutput("rst_m_address", mAddress, 16'd0);
        checkOutput("rst_m_wdata", mWdata, 16'd0);
        checkOutput("rst_i_rdata", iRdata, 16'd0);
        checkOutput("rst_d_rdata", dRdata, 16'd0);
    endtask

    task automatic doReset();
        logic acked;
        scoreCycle(acked);
        reset = 1'b1;
        dRdModel = 16'd0;
        scoreCycle(acked);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acked;
        logic anyActivity;
        int   n;
        logic orderD [4];

        reset = 1'b1; memLoad = 1'b1;
        iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        iAddress = '0; dAddress = '0; dWdata = '0;
        dRdModel = 16'd0;
        for (int k = 0; k < 256; k++) refMem[k] = initWord(8'(k));

        vecs[0]  = mkVec(1, 0, 0, 16'h0004, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mkVec(0, 1, 1, 16'h0000, 16'h0002, 16'hBEEF, 1, 1);
        vecs[2]  = mkVec(0, 1, 0, 16'h0000, 16'h0002, 16'h0000, 1, 1);
        vecs[3]  = mkVec(1, 1, 0, 16'h0010, 16'h0008, 16'h0000, 1, 0);
        vecs[4]  = mkVec(1, 0, 0, 16'h0003, 16'h0000, 16'h0000, 0, 0);
        vecs[5]  = mkVec(1, 1, 1, 16'h0006, 16'h0010, 16'h5555, 1, 1);
        vecs[6]  = mkVec(0, 1, 0, 16'h0000, 16'h0010, 16'h0000, 1, 1);
        vecs[7]  = mkVec(1, 0, 0, 16'h0002, 16'h0000, 16'h0000, 0, 0);
        vecs[8]  = mkVec(1, 1, 0, 16'h0008, 16'h00FF, 16'h0000, 1, 1);
        vecs[9]  = mkVec(0, 1, 1, 16'h0000, 16'h00FF, 16'hFFFF, 1, 1);
        vecs[10] = mkVec(1, 1, 0, 16'h0004, 16'h00FF, 16'h0000, 1, 0);
        vecs[11] = mkVec(0, 1, 0, 16'h0000, 16'h00FF, 16'h0000, 1, 1);

        repeat (2) @(negedge clk);
        memLoad = 1'b0;
        checkResetState();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Conflict: data wins, drops on its ack, fetch follows one full slot later.
        doReset();
        scoreCycle(acked);
        iReq = 1'b1; dReq = 1'b1; dWe = 1'b0; iAddress = 16'h0004; dAddress = 16'h0008;
        pushExpect(1'b1, 1'b0, 16'h0008, 16'h0000);
        pushExpect(1'b0, 1'b0, 16'h0004, 16'h0000);
        waitAck("conflict_d", n);
        dReq = 1'b0;
        waitAck("conflict_i", n);
        checkOutput("conflict_gap", n, LAT + 2);
        iReq = 1'b0;

        // Both requests held for four grants.
        doReset();
        orderD[0] = 1'b1;
        orderD[1] = RR ? 1'b0 : 1'b1;
        orderD[2] = 1'b1;
        orderD[3] = RR ? 1'b0 : 1'b1;
        scoreCycle(acked);
        iReq = 1'b1; dReq = 1'b1; dWe = 1'b0; iAddress = 16'h0004; dAddress = 16'h0008;
        for (int g = 0; g < 4; g++)
            pushExpect(orderD[g], 1'b0, orderD[g] ? 16'h0008 : 16'h0004, 16'h0000);
        for (int g = 0; g < 4; g++) waitAck("held", n);
        iReq = 1'b0; dReq = 1'b0;

        // Requester drops one cycle after grant: access completes, no refetch.
        scoreCycle(acked);
        scoreCycle(acked);
        iReq = 1'b1; iAddress = 16'h0004;
        pushExpect(1'b0, 1'b0, 16'h0004, 16'h0000);
        scoreCycle(acked);
        iReq = 1'b0;
        waitAck("drop", n);
        checkOutput("drop_latency", n, LAT);
        anyActivity = 1'b0;
        for (int c = 0; c < 6; c++) begin
            scoreCycle(acked);
            anyActivity = anyActivity | mReadM | mWriteM | acked;
        end
        checkOutput("drop_no_refetch", anyActivity, 1'b0);
        checkOutput("m_address_hold", mAddress, 16'h0004);

        // Reset during a read abandons it without an ack.
        scoreCycle(acked);
        iReq = 1'b1; iAddress = 16'h0010;
        scoreCycle(acked);
        checkOutput("mid_read_strobe", mReadM, 1'b1);
        reset = 1'b1;
        dRdModel = 16'd0;
        #1;
        checkResetState();
        iReq = 1'b0;
        scoreCycle(acked);
        reset = 1'b0;
        repeat (3) scoreCycle(acked);
        applyStimulus(mkVec(1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0));
        repeat (3) scoreCycle(acked);

        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
